// File: rtl/ysyx_22041461_sram_resp_if.sv
// rtl/ysyx_22041461_sram_resp_if.sv - request/response channel bundle for the SRAM responder
interface ysyx_22041461_sram_resp_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/ysyx_22041461_sram_resp.sv
// rtl/ysyx_22041461_sram_resp.sv - fixed-latency 64-bit byte-masked memory responder
module ysyx_22041461_sram_resp #(
  parameter logic [63:0] ADDR_BASE   = 64'h0000_0000_8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2
) (
  input logic                          clk,
  input logic                          rst,
  ysyx_22041461_sram_resp_if.slave     bus
);

  localparam int          IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [63:0] ADDR_END = ADDR_BASE + 64'(DEPTH_WORDS) * 64'd8;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [7:0]  r_wmask;
  logic [63:0] r_rdata;
  logic        r_err;
  logic [63:0] r_mem [DEPTH_WORDS];

  logic             w_accept;
  logic             w_fire;
  logic             w_rsp_hs;
  logic             w_in_range;
  logic [63:0]      w_off;
  logic [IDX_W-1:0] w_idx;
  logic [63:0]      w_rd_word;
  logic             w_unused_off;

  // Range test is done on the full 64-bit address so nothing below the base aliases in
  assign w_in_range   = (r_addr >= ADDR_BASE) && (r_addr < ADDR_END);
  assign w_off        = r_addr - ADDR_BASE;
  assign w_idx        = w_off[IDX_W+2:3];
  assign w_unused_off = ^{w_off[63:IDX_W+3], w_off[2:0]};
  assign w_rd_word    = r_mem[w_idx];

  assign w_accept = (r_state == S_IDLE) && bus.req_valid;
  assign w_fire   = (r_state == S_WAIT) && (r_cnt == 4'd0);
  assign w_rsp_hs = (r_state == S_RESP) && bus.rsp_ready;

  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.rsp_valid = (r_state == S_RESP);
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.req_valid) w_next = S_WAIT;
      S_WAIT:  if (r_cnt == 4'd0) w_next = S_RESP;
      S_RESP:  if (bus.rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= 64'd0;
      r_wdata <= 64'd0;
      r_wmask <= 8'd0;
      r_rdata <= 64'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we    <= bus.req_we;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_wmask <= bus.req_wmask;
        r_cnt   <= 4'(LATENCY - 1);
      end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_fire) begin
        r_err   <= ~w_in_range;
        r_rdata <= (w_in_range && !r_we) ? w_rd_word : 64'd0;
      end else if (w_rsp_hs) begin
        r_err   <= 1'b0;
        r_rdata <= 64'd0;
      end
    end
  end

  // Storage is not reset; a reset forces IDLE so an in-flight write never reaches here
  always_ff @(posedge clk) begin
    if (w_fire && r_we && w_in_range) begin
      for (int i = 0; i < 8; i++) begin
        if (r_wmask[i]) r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
      end
    end
  end

endmodule
